bitwise_logic_pipe: RTL

BITWISE_LOGIC_PIPE -- requirements
Module: bitwise_logic_pipe

---
 rtl/bitwise_logic_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bitwise_logic_pipe.sv
// Purpose: two-stage registered bitwise logic unit (AND/OR/XOR/NAND/NOR/XNOR/ANDN/PASS) with valid/ready handshake.
// Latency: 2 cycles from input acceptance to out_valid; full throughput, one beat per cycle.
// Backpressure: out_ready low stalls S2, S1 absorbs one more beat, then in_ready drops; outputs held stable.
// Optional accumulator operand (acc_sel/acc_clr) is built only when BITWISE_LOGIC_PIPE_ACC_EN is defined.
module bitwise_logic_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ANDN = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // Stage 1 holding registers
  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  // Stage 2 result registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;

  // Handshake and datapath wires
  logic             w_s2_advance;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_s1_move;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_result;

  // S2 can take a new beat when it is empty or its beat is leaving this cycle.
  assign w_s2_advance = !r_out_valid || out_ready;
  assign w_in_ready   = !r_s1_valid || w_s2_advance;
  assign w_accept     = in_valid && w_in_ready;
  assign w_s1_move    = r_s1_valid && w_s2_advance;

`ifdef BITWISE_LOGIC_PIPE_ACC_EN
  logic             r_s1_acc_sel;
  logic [WIDTH-1:0] r_acc;

  // The accumulator is read at the S1->S2 transfer, so a chained beat sees the
  // value written by the beat one cycle ahead of it without any forwarding.
  assign w_op_a = r_s1_acc_sel ? r_acc : r_s1_a;

  // Capture the accumulator-select flag alongside the operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_acc_sel <= 1'b0;
    end else if (w_accept) begin
      r_s1_acc_sel <= acc_sel;
    end
  end

  // Accumulator: clear beats a coincident write-back; reset beats both.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '1;
    end else if (acc_clr) begin
      r_acc <= '1;
    end else if (w_s1_move && r_s1_acc_sel) begin
      r_acc <= w_result;
    end
  end
`else
  // Accumulator controls stay on the port list but have no effect in this build.
  logic w_unused_acc;
  assign w_unused_acc = acc_sel ^ acc_clr;
  assign w_op_a       = r_s1_a;
`endif

  // Stage 1: load operands on acceptance; valid follows in_valid whenever S1 is free to change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= 3'd0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_s1_op <= op;
        r_s1_a  <= a;
        r_s1_b  <= b;
      end
    end
  end

  // Bitwise operation decode on the stage-1 operands.
  always_comb begin
    w_result = '0;
    case (r_s1_op)
      OP_AND:  w_result = w_op_a & r_s1_b;
      OP_OR:   w_result = w_op_a | r_s1_b;
      OP_XOR:  w_result = w_op_a ^ r_s1_b;
      OP_NAND: w_result = ~(w_op_a & r_s1_b);
      OP_NOR:  w_result = ~(w_op_a | r_s1_b);
      OP_XNOR: w_result = ~(w_op_a ^ r_s1_b);
      OP_ANDN: w_result = w_op_a & ~r_s1_b;
      OP_PASS: w_result = r_s1_b;
      default: w_result = '0;
    endcase
  end

  // Stage 2: register result and zero flag; hold everything while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_zero      <= 1'b0;
    end else if (w_s2_advance) begin
      r_out_valid <= r_s1_valid;
      if (w_s1_move) begin
        r_y    <= w_result;
        r_zero <= ~|w_result;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign zero      = r_zero && r_out_valid;

endmodule
